// File: rtl/refill_pkg.sv
// Shared definitions for the refill response serializer.
//   OKAY/EXOKAY/SLVERR/DECERR : AXI4 response codes
//   state_e                   : serializer FSM encoding
//   beats()                   : number of R beats per cache line
package refill_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    function automatic int beats(input int cache_line, input int icache_data_width,
                                 input int axi_data);
        return (cache_line * icache_data_width) / axi_data;
    endfunction

endpackage

// File: rtl/refill_line_reg.sv
// One-entry line holding register with load/clear and a valid flag.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load, d    : capture d and set valid (load wins over clear)
//   clear      : drop valid, contents are kept
//   valid, q   : holding state
module refill_line_reg
    import refill_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axi4_refill_resp_serializer.sv
// Serializes one wide cache-line response into an AXI4 R-channel burst of
// AXI_DATA-wide beats, rlast on the final beat. line_single_i emits only
// beat 0 (bypass / uncached traffic).
// Optional feature macro: REFILL_SER_PREFETCH_EN adds a one-entry pending
// line so consecutive lines stream with no idle R cycle between them.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   line_*             : wide line input, valid/ready handshake
//   init_r*            : AXI4 R channel output, rvalid/rready handshake
//
// state | meaning
// IDLE  | no active line; line input accepted
// SEND  | streaming beats of the active line
module axi4_refill_resp_serializer
    import refill_pkg::*;
#(
    parameter int CACHE_LINE        = 4,
    parameter int ICACHE_DATA_WIDTH = 32,
    parameter int AXI_ID            = 6,
    parameter int AXI_DATA          = 64,
    parameter int AXI_USER          = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  line_valid_i,
    output logic                                  line_ready_o,
    input  logic                                  line_single_i,
    input  logic [AXI_ID-1:0]                     line_rid_i,
    input  logic [1:0]                            line_rresp_i,
    input  logic [AXI_USER-1:0]                   line_ruser_i,
    input  logic [CACHE_LINE*ICACHE_DATA_WIDTH-1:0] line_rdata_i,
    output logic [AXI_ID-1:0]                     init_rid_o,
    output logic [AXI_DATA-1:0]                   init_rdata_o,
    output logic [1:0]                            init_rresp_o,
    output logic                                  init_rlast_o,
    output logic [AXI_USER-1:0]                   init_ruser_o,
    output logic                                  init_rvalid_o,
    input  logic                                  init_rready_i
);

    localparam int LINE_W = CACHE_LINE * ICACHE_DATA_WIDTH;
    localparam int BEATS  = beats(CACHE_LINE, ICACHE_DATA_WIDTH, AXI_DATA);
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ENT_W  = 1 + AXI_ID + 2 + AXI_USER + LINE_W;

    localparam logic [0:0]       S_IDLE    = IDLE;
    localparam logic [0:0]       S_SEND    = SEND;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BEATS - 1);

    if (((LINE_W % AXI_DATA) != 0) || (BEATS < 1)) begin : g_param_check
        $fatal(1, "axi4_refill_resp_serializer: line width must be a whole number of AXI beats");
    end

    logic [0:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    last_idx;
    logic                send;
    logic                line_hs;
    logic                beat_hs;
    logic                last_hs;

    logic [ENT_W-1:0]    line_in;
    logic [ENT_W-1:0]    act_d;
    logic [ENT_W-1:0]    act_q;
    logic                act_load;
    logic                act_clear;
    logic                act_valid;

    logic                act_single;
    logic [AXI_ID-1:0]   act_rid;
    logic [1:0]          act_rresp;
    logic [AXI_USER-1:0] act_ruser;
    logic [LINE_W-1:0]   act_data;

    assign line_in = {line_single_i, line_rid_i, line_rresp_i, line_ruser_i, line_rdata_i};
    assign {act_single, act_rid, act_rresp, act_ruser, act_data} = act_q;

    assign send     = (state == S_SEND) && act_valid;
    assign line_hs  = line_valid_i && line_ready_o;
    assign beat_hs  = send && init_rready_i;
    // single only shortens a multi-beat line; with one beat it is already last
    assign last_idx = act_single ? '0 : FULL_LAST;
    assign last_hs  = beat_hs && (cnt == last_idx);

`ifdef REFILL_SER_PREFETCH_EN
    logic             pend_load;
    logic             pend_clear;
    logic             pend_valid;
    logic [ENT_W-1:0] pend_q;

    always_comb begin
        line_ready_o = !rst && ((state == S_IDLE) || !pend_valid);
        // a line arriving on the last beat bypasses the pending slot
        pend_load    = line_hs && (state == S_SEND) && !last_hs;
        pend_clear   = last_hs && pend_valid;
        act_load     = (line_hs && ((state == S_IDLE) || last_hs)) || (last_hs && pend_valid);
        act_d        = (last_hs && pend_valid) ? pend_q : line_in;
        act_clear    = last_hs && !act_load;
    end

    refill_line_reg #(.W(ENT_W)) u_pend_line (
        .clk   (clk),
        .rst   (rst),
        .load  (pend_load),
        .clear (pend_clear),
        .d     (line_in),
        .valid (pend_valid),
        .q     (pend_q)
    );
`else
    always_comb begin
        line_ready_o = !rst && (state == S_IDLE);
        act_load     = line_hs;
        act_d        = line_in;
        act_clear    = last_hs;
    end
`endif

    refill_line_reg #(.W(ENT_W)) u_act_line (
        .clk   (clk),
        .rst   (rst),
        .load  (act_load),
        .clear (act_clear),
        .d     (act_d),
        .valid (act_valid),
        .q     (act_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (act_load) begin
            state <= S_SEND;
            cnt   <= '0;
        end else if (last_hs) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (beat_hs) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // outputs are forced to zero outside SEND so IDLE shows a clean bus
    assign init_rvalid_o = send;
    assign init_rdata_o  = send ? act_data[int'(cnt)*AXI_DATA +: AXI_DATA] : '0;
    assign init_rid_o    = send ? act_rid   : '0;
    assign init_rresp_o  = send ? act_rresp : '0;
    assign init_ruser_o  = send ? act_ruser : '0;
    assign init_rlast_o  = send && (cnt == last_idx);

endmodule

// File: tb/tb_axi4_refill_resp_serializer.sv
module tb_axi4_refill_resp_serializer;
    import refill_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // default-parameter instance
    logic         line_valid, line_ready, line_single;
    logic [5:0]   line_rid;
    logic [1:0]   line_rresp;
    logic [7:0]   line_ruser;
    logic [127:0] line_rdata;
    logic [5:0]   rid;
    logic [63:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;
    logic [7:0]   ruser;

    axi4_refill_resp_serializer dut (
        .clk(clk), .rst(rst),
        .line_valid_i(line_valid), .line_ready_o(line_ready), .line_single_i(line_single),
        .line_rid_i(line_rid), .line_rresp_i(line_rresp), .line_ruser_i(line_ruser),
        .line_rdata_i(line_rdata),
        .init_rid_o(rid), .init_rdata_o(rdata), .init_rresp_o(rresp), .init_rlast_o(rlast),
        .init_ruser_o(ruser), .init_rvalid_o(rvalid), .init_rready_i(rready)
    );

    // one-beat-per-line instance
    logic         l2_valid, l2_ready, l2_single;
    logic [5:0]   l2_rid;
    logic [127:0] l2_rdata;
    logic [5:0]   rid2;
    logic [127:0] rdata2;
    logic [1:0]   rresp2;
    logic         rlast2, rvalid2;
    logic [7:0]   ruser2;

    axi4_refill_resp_serializer #(.AXI_DATA(128)) dut2 (
        .clk(clk), .rst(rst),
        .line_valid_i(l2_valid), .line_ready_o(l2_ready), .line_single_i(l2_single),
        .line_rid_i(l2_rid), .line_rresp_i(OKAY), .line_ruser_i(8'h00),
        .line_rdata_i(l2_rdata),
        .init_rid_o(rid2), .init_rdata_o(rdata2), .init_rresp_o(rresp2), .init_rlast_o(rlast2),
        .init_ruser_o(ruser2), .init_rvalid_o(rvalid2), .init_rready_i(1'b1)
    );

    typedef struct packed {
        logic [5:0]  rid;
        logic [63:0] rdata;
        logic [1:0]  rresp;
        logic [7:0]  ruser;
        logic        rlast;
    } beat_t;

    typedef struct packed {
        logic [5:0]   rid;
        logic [127:0] rdata;
        logic         rlast;
    } beat2_t;

    beat_t  exp_q[$];
    beat2_t q2[$];
    int     beat_cyc[$];
    int     stall_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor for the default instance: scoreboard pops plus hold-while-stalled
    initial begin : mon1
        logic [80:0] held;
        bit          stalled = 0;
        beat_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 0;
            end else begin
                if (stalled)
                    chk("stall_hold", {rvalid, rid, rdata, rresp, ruser}, held);
                stalled = rvalid && !rready;
                if (stalled) begin
                    held = {rvalid, rid, rdata, rresp, ruser};
                    stall_cnt++;
                end
                if (rvalid && rready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", rdata, 0);
                        if (rdata == 0) chk("unexpected_beat_valid", rvalid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_rid", rid, e.rid);
                        chk("beat_rdata", rdata, e.rdata);
                        chk("beat_rresp", rresp, e.rresp);
                        chk("beat_ruser", ruser, e.ruser);
                        chk("beat_rlast", rlast, e.rlast);
                        beat_cyc.push_back(cyc + 1);
                    end
                end
            end
        end
    end

    initial begin : mon2
        beat2_t e;
        forever begin
            @(negedge clk);
            if (!rst && rvalid2) begin
                if (q2.size() == 0) begin
                    chk("unexpected_beat2_valid", rvalid2, 0);
                end else begin
                    e = q2.pop_front();
                    chk("b1_rid", rid2, e.rid);
                    chk("b1_rdata", rdata2, e.rdata);
                    chk("b1_rlast", rlast2, e.rlast);
                    chk("b1_rresp", rresp2, OKAY);
                end
            end
        end
    end

    // call at #1 after a posedge; returns at #1 after the handshake edge
    task automatic offer(input logic single, input logic [5:0] id, input logic [1:0] resp,
                         input logic [7:0] user, input logic [127:0] data, input bit only_first,
                         output int hs);
        int    n = 0;
        beat_t b;
        hs = -1;
        line_valid = 1; line_single = single; line_rid = id;
        line_rresp = resp; line_ruser = user; line_rdata = data;
        while (n < 50) begin
            @(negedge clk);
            if (line_ready) begin
                @(posedge clk); #1;
                hs = cyc;
                break;
            end
            n++;
        end
        line_valid = 0;
        chk("line_accept_timeout", hs >= 0, 1);
        b.rid = id; b.rresp = resp; b.ruser = user;
        b.rdata = data[63:0];
        b.rlast = single;
        exp_q.push_back(b);
        if (!single && !only_first) begin
            b.rdata = data[127:64];
            b.rlast = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    task automatic offer2(input logic single, input logic [5:0] id, input logic [127:0] data);
        int     n = 0;
        bit     ok = 0;
        beat2_t b;
        l2_valid = 1; l2_single = single; l2_rid = id; l2_rdata = data;
        while (n < 50) begin
            @(negedge clk);
            if (l2_ready) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
            n++;
        end
        l2_valid = 0;
        chk("line2_accept_timeout", ok, 1);
        b.rid = id; b.rdata = data; b.rlast = 1'b1;
        q2.push_back(b);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || q2.size() != 0 || rvalid || rvalid2) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", n < 200, 1);
        @(posedge clk); #1;
    endtask

    localparam logic [127:0] LINE_A = 128'h4444_3333_2222_1111_DDDD_CCCC_BBBB_AAAA;
    localparam logic [127:0] LINE_B = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
    localparam logic [127:0] LINE_C = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_5555_AAAA;

    initial begin : stim
        int hs, hs_b;
        rst = 1; rready = 1;
        line_valid = 0; line_single = 0; line_rid = '0; line_rresp = '0;
        line_ruser = '0; line_rdata = '0;
        l2_valid = 0; l2_single = 0; l2_rid = '0; l2_rdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_line_ready", line_ready, 0);
        chk("rst_rvalid", rvalid, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("post_rst_line_ready", line_ready, 1);
        chk("post_rst_rvalid", rvalid, 0);
        chk("post_rst_rlast", rlast, 0);
        chk("post_rst_rdata", rdata, 0);
        chk("post_rst_rid", rid, 0);
        @(posedge clk); #1;

        // full line, two beats back to back one cycle after the handshake
        beat_cyc.delete();
        offer(0, 6'h15, OKAY, 8'h5A, LINE_A, 0, hs);
        wait_idle();
        chk("basic_beat0_cycle", beat_cyc[0], hs + 1);
        chk("basic_beat1_cycle", beat_cyc[1], hs + 2);

        // single-beat response, FSM idle right after
        beat_cyc.delete();
        offer(1, 6'h2A, SLVERR, 8'hC3, LINE_B, 0, hs);
        @(posedge clk);
        @(negedge clk);
        chk("single_back_idle_ready", line_ready, 1);
        chk("single_back_idle_rvalid", rvalid, 0);
        chk("single_beat_cycle", beat_cyc[0], hs + 1);
        wait_idle();

        // rready held low three cycles on beat 0
        beat_cyc.delete();
        stall_cnt = 0;
        rready = 0;
        offer(0, 6'h07, EXOKAY, 8'h11, LINE_C, 0, hs);
        repeat (3) @(posedge clk);
        #1 rready = 1;
        wait_idle();
        chk("stall_cycles", stall_cnt, 3);
        chk("stall_beat0_cycle", beat_cyc[0], hs + 4);
        chk("stall_beat1_cycle", beat_cyc[1], hs + 5);

        // two lines back to back
        beat_cyc.delete();
        offer(0, 6'h01, OKAY, 8'h01, LINE_A, 0, hs);
        offer(0, 6'h02, DECERR, 8'h02, LINE_B, 0, hs_b);
        wait_idle();
        chk("b2b_beat_count", beat_cyc.size(), 4);
`ifdef REFILL_SER_PREFETCH_EN
        chk("b2b_second_accept", hs_b, hs + 1);
        chk("b2b_beat2_cycle", beat_cyc[2], hs + 3);
        chk("b2b_last_cycle", beat_cyc[3], hs + 4);
`else
        chk("b2b_second_accept", hs_b, hs + 3);
        chk("b2b_beat2_cycle", beat_cyc[2], hs + 4);
        chk("b2b_last_cycle", beat_cyc[3], hs + 5);
`endif

        // reset right after beat 0 handshake abandons the burst
        beat_cyc.delete();
        offer(0, 6'h33, OKAY, 8'h44, LINE_C, 1, hs);
        @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("midrst_line_ready_low", line_ready, 0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_rlast", rlast, 0);
        chk("midrst_line_ready", line_ready, 1);
        @(posedge clk); #1;
        offer(0, 6'h34, OKAY, 8'h45, LINE_B, 0, hs);
        wait_idle();
        chk("midrst_beats_total", beat_cyc.size(), 3);
        chk("midrst_restart_cycle", beat_cyc[1], hs + 1);

        // one beat per line: rlast on every beat regardless of single
        offer2(0, 6'h0A, LINE_A);
        wait_idle();
        offer2(1, 6'h0B, LINE_C);
        wait_idle();

        chk("exp_q_drained", exp_q.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
